// File: rtl/snn_pkg.sv
// Shared SNN definitions: default datapath sizes used by the post-synaptic
// neuron and the STDP learning block, plus the neuron state encoding.
package snn_pkg;

  localparam int unsigned SNN_NUM_PRE = 5;   // presynaptic inputs
  localparam int unsigned SNN_W_WIDTH = 8;   // unsigned synaptic weight width
  localparam int unsigned SNN_V_WIDTH = 10;  // unsigned membrane potential width

  typedef enum logic {
    INTEG   = 1'b0,
    REFRACT = 1'b1
  } neuron_state_t;

endpackage

// File: rtl/lif_post_neuron_if.sv
// Neuron bus: presynaptic spikes, weight write port, threshold (driven by the
// master) and the neuron outputs (driven by the slave).
//   pre_spike   spike vector, one bit per presynaptic input
//   w_wr_en     weight write strobe; w_addr / w_data select and supply it
//   thresh      firing threshold (unsigned)
//   post_spike  one-cycle fire pulse
//   v_mem       membrane potential
//   refractory  high while input is blanked after a spike
//   spike_count fires since reset, wraps at 8 bits
interface lif_post_neuron_if
  import snn_pkg::*;
#(
  parameter int unsigned NUM_PRE = SNN_NUM_PRE,
  parameter int unsigned W_WIDTH = SNN_W_WIDTH,
  parameter int unsigned V_WIDTH = SNN_V_WIDTH
) ();

  logic [NUM_PRE-1:0] pre_spike;
  logic               w_wr_en;
  logic [2:0]         w_addr;
  logic [W_WIDTH-1:0] w_data;
  logic [V_WIDTH-1:0] thresh;
  logic               post_spike;
  logic [V_WIDTH-1:0] v_mem;
  logic               refractory;
  logic [7:0]         spike_count;

  modport master (
    output pre_spike, w_wr_en, w_addr, w_data, thresh,
    input  post_spike, v_mem, refractory, spike_count
  );

  modport slave (
    input  pre_spike, w_wr_en, w_addr, w_data, thresh,
    output post_spike, v_mem, refractory, spike_count
  );

endinterface

// File: rtl/snn_weight_regfile.sv
// Synaptic weight storage: NUM_PRE x W_WIDTH registers with a single write
// port and a parallel read of every weight.
//   clk, rst_n  clock, async active-low reset (clears all weights)
//   wr_en       write strobe
//   addr        weight index; indices >= NUM_PRE are ignored
//   wdata       value written
//   weights     all weights, weights[i] is synapse i
module snn_weight_regfile #(
  parameter int unsigned NUM_PRE = 5,
  parameter int unsigned W_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [2:0]                      addr,
  input  logic [W_WIDTH-1:0]              wdata,
  output logic [NUM_PRE-1:0][W_WIDTH-1:0] weights
);

  // Per-entry address decode so an out-of-range index matches nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PRE; i++) begin
        if (wr_en && (addr == 3'(i))) begin
          weights[i] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire post-synaptic neuron. Each cycle in INTEG it leaks
// v_mem by v_mem >> LEAK_SHIFT, adds the weights of the active presynaptic
// inputs, saturates, and fires when the result reaches thresh. After a fire it
// blanks its input for REFRACT_CYCLES cycles.
//   clk, rst_n  clock, async active-low reset
//   bus         lif_post_neuron_if slave: spikes, weight write, threshold in;
//               post_spike, v_mem, refractory, spike_count out
module lif_post_neuron
  import snn_pkg::*;
#(
  parameter int unsigned NUM_PRE        = SNN_NUM_PRE,
  parameter int unsigned W_WIDTH        = SNN_W_WIDTH,
  parameter int unsigned V_WIDTH        = SNN_V_WIDTH,
  parameter int unsigned LEAK_SHIFT     = 3,
  parameter int unsigned REFRACT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  lif_post_neuron_if.slave bus
);

  localparam int unsigned SUM_W = W_WIDTH + 3;
  localparam int unsigned RAW_W = V_WIDTH + 4;
  localparam int unsigned CNT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [V_WIDTH-1:0] V_MAX = '1;

  logic [NUM_PRE-1:0][W_WIDTH-1:0] weights;
  logic [SUM_W-1:0]                sum;
  logic [V_WIDTH-1:0]              leak;
  logic [RAW_W-1:0]                v_raw;
  logic [V_WIDTH-1:0]              v_next;
  logic                            fire;

  neuron_state_t      state;
  logic [CNT_W-1:0]   refr_cnt;
  logic [V_WIDTH-1:0] v_q;
  logic               post_q;
  logic               refr_q;
  logic [7:0]         count_q;

  snn_weight_regfile #(
    .NUM_PRE (NUM_PRE),
    .W_WIDTH (W_WIDTH)
  ) u_wregs (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.w_wr_en),
    .addr    (bus.w_addr),
    .wdata   (bus.w_data),
    .weights (weights)
  );

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++) begin
      if (bus.pre_spike[i]) begin
        sum = sum + SUM_W'(weights[i]);
      end
    end
  end

  always_comb begin
    leak = '0;
    if (LEAK_SHIFT != 0) begin
      leak = v_q >> LEAK_SHIFT;
    end
  end

  // leak <= v_q, so the subtraction cannot underflow.
  assign v_raw  = RAW_W'(v_q) - RAW_W'(leak) + RAW_W'(sum);
  // Clamp before the compare so thresh = V_MAX is reachable.
  assign v_next = (v_raw > RAW_W'(V_MAX)) ? V_MAX : v_raw[V_WIDTH-1:0];
  assign fire   = (state == INTEG) && (v_next >= bus.thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INTEG;
      refr_cnt <= '0;
      v_q      <= '0;
      post_q   <= 1'b0;
      refr_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state)
        INTEG: begin
          if (fire) begin
            post_q  <= 1'b1;
            v_q     <= '0;
            count_q <= count_q + 8'd1;
            if (REFRACT_CYCLES > 0) begin
              refr_cnt <= CNT_W'(REFRACT_CYCLES);
              state    <= REFRACT;
              refr_q   <= 1'b1;
            end
          end else begin
            post_q <= 1'b0;
            v_q    <= v_next;
          end
        end
        REFRACT: begin
          post_q   <= 1'b0;
          v_q      <= '0;
          refr_cnt <= refr_cnt - 1'b1;
          if (refr_cnt == CNT_W'(1)) begin
            state  <= INTEG;
            refr_q <= 1'b0;
          end
        end
        default: begin
          state <= INTEG;
        end
      endcase
    end
  end

  assign bus.post_spike  = post_q;
  assign bus.v_mem       = v_q;
  assign bus.refractory  = refr_q;
  assign bus.spike_count = count_q;

endmodule

// File: tb/tb_lif_post_neuron.sv
module tb_lif_post_neuron;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] pre = '0;
  logic       w_en = 1'b0;
  logic [2:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [9:0] thresh = 10'd1023;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // dut_a: leak shift 3, refractory 4. dut_b: no leak, no refractory.
  lif_post_neuron_if #(.NUM_PRE(5), .W_WIDTH(8), .V_WIDTH(10)) bus_a ();
  lif_post_neuron_if #(.NUM_PRE(5), .W_WIDTH(8), .V_WIDTH(10)) bus_b ();

  assign bus_a.pre_spike = pre;
  assign bus_a.w_wr_en   = w_en;
  assign bus_a.w_addr    = waddr;
  assign bus_a.w_data    = wdata;
  assign bus_a.thresh    = thresh;
  assign bus_b.pre_spike = pre;
  assign bus_b.w_wr_en   = w_en;
  assign bus_b.w_addr    = waddr;
  assign bus_b.w_data    = wdata;
  assign bus_b.thresh    = thresh;

  lif_post_neuron #(
    .NUM_PRE(5), .W_WIDTH(8), .V_WIDTH(10), .LEAK_SHIFT(3), .REFRACT_CYCLES(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );

  lif_post_neuron #(
    .NUM_PRE(5), .W_WIDTH(8), .V_WIDTH(10), .LEAK_SHIFT(0), .REFRACT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  // ---------------- behavioural model ----------------
  int m_w[2][5];
  int m_v[2];
  int m_post[2];
  int m_blank[2];   // remaining blanked cycles
  int m_count[2];

  function automatic int leak_shift_of(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  function automatic int refract_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic int weighted_sum(input int d, input logic [4:0] p);
    int s = 0;
    for (int i = 0; i < 5; i++) if (p[i]) s += m_w[d][i];
    return s;
  endfunction

  function automatic int next_potential(input int v, input int s, input int ls);
    int r = v - ((ls == 0) ? 0 : (v >> ls)) + s;
    return (r > 1023) ? 1023 : r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_v[d] <= 0; m_post[d] <= 0; m_blank[d] <= 0; m_count[d] <= 0;
        for (int i = 0; i < 5; i++) m_w[d][i] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_blank[d] > 0) begin
          m_blank[d] <= m_blank[d] - 1;
          m_v[d]     <= 0;
          m_post[d]  <= 0;
        end else if (next_potential(m_v[d], weighted_sum(d, pre), leak_shift_of(d)) >= int'(thresh)) begin
          m_post[d]  <= 1;
          m_v[d]     <= 0;
          m_count[d] <= (m_count[d] + 1) % 256;
          m_blank[d] <= refract_of(d);
        end else begin
          m_post[d] <= 0;
          m_v[d]    <= next_potential(m_v[d], weighted_sum(d, pre), leak_shift_of(d));
        end
        if (w_en && waddr < 3'd5) m_w[d][waddr] <= int'(wdata);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_post",  32'(bus_a.post_spike),  32'(m_post[0]));
      chk("a_v",     32'(bus_a.v_mem),       32'(m_v[0]));
      chk("a_refr",  32'(bus_a.refractory),  32'(m_blank[0] > 0));
      chk("a_count", 32'(bus_a.spike_count), 32'(m_count[0]));
      chk("b_post",  32'(bus_b.post_spike),  32'(m_post[1]));
      chk("b_v",     32'(bus_b.v_mem),       32'(m_v[1]));
      chk("b_refr",  32'(bus_b.refractory),  32'(m_blank[1] > 0));
      chk("b_count", 32'(bus_b.spike_count), 32'(m_count[1]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int dval);
    w_en = 1'b1; waddr = 3'(a); wdata = 8'(dval);
    tick();
    w_en = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-integration
    wr(0, 150);
    pre = 5'b00001; tick(); pre = '0;
    chk("lit_pre_reset_v", 32'(bus_a.v_mem), 32'd150);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_v",     32'(bus_a.v_mem),       32'd0);
    chk("lit_rst_post",  32'(bus_a.post_spike),  32'd0);
    chk("lit_rst_count", 32'(bus_a.spike_count), 32'd0);
    for (int i = 0; i < 5; i++) chk("lit_rst_weight", 32'(dut_a.u_wregs.weights[i]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    thresh = 10'd1; pre = 5'b11111; tick(); pre = '0;
    chk("lit_zero_weights_v", 32'(bus_a.v_mem), 32'd0);

    // Basic fire with leak
    thresh = 10'd200;
    for (int i = 0; i < 5; i++) wr(i, 64);
    pre = 5'b00111; tick(); pre = '0;
    chk("lit_fire_v192", 32'(bus_a.v_mem), 32'd192);
    tick();
    chk("lit_fire_v168", 32'(bus_a.v_mem), 32'd168);
    pre = 5'b00001; tick(); pre = '0;
    chk("lit_fire_post",  32'(bus_a.post_spike),  32'd1);
    chk("lit_fire_v0",    32'(bus_a.v_mem),       32'd0);
    chk("lit_fire_count", 32'(bus_a.spike_count), 32'd1);
    repeat (6) tick();

    // Refractory spacing with input held
    thresh = 10'd10;
    for (int i = 0; i < 5; i++) wr(i, 255);
    pre = 5'b11111;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("lit_refr_post", 32'(bus_a.post_spike), 32'((k % 5) == 0));
      chk("lit_refr_flag", 32'(bus_a.refractory), 32'((k % 5) != 4));
    end
    pre = '0;

    // Saturation without leak
    thresh = 10'd1023;
    tick();
    pre = 5'b00001;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("lit_sat_v", 32'(bus_b.v_mem), 32'(255 * k));
    end
    tick();
    chk("lit_sat_post", 32'(bus_b.post_spike), 32'd1);
    chk("lit_sat_v0",   32'(bus_b.v_mem),      32'd0);
    pre = '0;

    // Write/spike collision and out-of-range address
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    wr(0, 20);
    w_en = 1'b1; waddr = 3'd0; wdata = 8'd100; pre = 5'b00001;
    tick();
    w_en = 1'b0;
    chk("lit_coll_a_old", 32'(bus_a.v_mem), 32'd20);
    chk("lit_coll_b_old", 32'(bus_b.v_mem), 32'd20);
    tick();
    chk("lit_coll_a_new", 32'(bus_a.v_mem), 32'd118);
    chk("lit_coll_b_new", 32'(bus_b.v_mem), 32'd120);
    pre = '0;
    wr(6, 77);
    pre = 5'b11111; tick(); pre = '0;
    chk("lit_badaddr_b", 32'(bus_b.v_mem), 32'd220);
    chk("lit_badaddr_a", 32'(bus_a.v_mem), 32'd191);

    // spike_count wrap with thresh = 0
    thresh = 10'd0;
    repeat (255) tick();
    chk("lit_wrap_255", 32'(bus_b.spike_count), 32'd255);
    tick();
    chk("lit_wrap_0", 32'(bus_b.spike_count), 32'd0);
    chk("lit_wrap_post", 32'(bus_b.post_spike), 32'd1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_post_neuron.md
Name: lif_post_neuron

Overview:
Leaky integrate-and-fire postsynaptic neuron. It is the producer of the post-synaptic spike that the STDP learning block consumes.
- Integrates weighted pre-synaptic spikes from the same 5-input bus the STDP block observes.
- Applies a shift-based leak and fires a one-cycle post_spike pulse when the membrane potential crosses the threshold.
- Holds a refractory period after each spike.
- Weights are loaded through a simple write port, so learned STDP weights can be written back.

Parameters:
NUM_PRE, 5, number of presynaptic inputs
W_WIDTH, 8, unsigned synaptic weight width
V_WIDTH, 10, unsigned membrane potential width (saturates at 2^V_WIDTH-1)
LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT per cycle; 0 disables leak
REFRACT_CYCLES, 4, cycles of input blanking after a spike; 0 = no refractory period

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low
pre_spike  input  NUM_PRE  presynaptic spike vector, sampled each clk edge
w_wr_en  input  1  weight write strobe
w_addr  input  3  weight index (0..NUM_PRE-1)
w_data  input  W_WIDTH  weight value to write
thresh  input  V_WIDTH  firing threshold, compared unsigned
post_spike  output  1  registered one-cycle fire pulse
v_mem  output  V_WIDTH  current membrane potential (registered)
refractory  output  1  high while in REFRACT state
spike_count  output  8  total fires since reset, wraps 255->0

Behaviour:
- Reset (async, rst_n=0):
  - all weights 0, v_mem 0, post_spike 0, refractory 0, spike_count 0;
  - state INTEG, refractory counter 0.
  - Deassertion mid-operation restarts from these values; any in-flight spike is lost.
- Weight write: on an edge with w_wr_en=1 and w_addr<NUM_PRE, weights[w_addr] <= w_data. w_addr>=NUM_PRE is ignored.
  - Writes are accepted in any state.
  - A write and a spike in the same cycle: integration uses the old weight; the new weight applies from the next edge.
- Integration arithmetic (combinational, state INTEG):
  - sum = sum of weights[i] where pre_spike[i]=1, width W_WIDTH+3.
  - leak = (LEAK_SHIFT==0) ? 0 : v_mem >> LEAK_SHIFT.
  - v_raw = v_mem - leak + sum, computed at V_WIDTH+4 bits, never negative.
  - v_next = min(v_raw, 2^V_WIDTH-1), i.e. saturating.
- FSM states: INTEG, REFRACT.
  - INTEG, v_next >= thresh:
    - post_spike<=1, v_mem<=0, spike_count<=spike_count+1;
    - if REFRACT_CYCLES>0: counter<=REFRACT_CYCLES, state<=REFRACT, refractory<=1; else stay in INTEG.
  - INTEG, v_next < thresh: v_mem<=v_next, post_spike<=0.
  - REFRACT: pre_spike ignored, v_mem held at 0, post_spike<=0, counter decrements. When the counter is 1, the next edge enters INTEG with refractory<=0.
    - Result: exactly REFRACT_CYCLES cycles are blanked.
- Latency: pre_spike sampled at edge N produces post_spike high from edge N to edge N+1.
- thresh=0: every INTEG cycle fires, including cycles with no input.
- Saturation: v_next is clamped before comparison, so thresh=2^V_WIDTH-1 is reachable.
- post_spike is never high on two consecutive cycles when REFRACT_CYCLES>0.

Decomposition:
- Shared package snn_pkg: NUM_PRE, W_WIDTH, V_WIDTH defaults, and the neuron state enum {INTEG, REFRACT}. The STDP block imports the same NUM_PRE/W_WIDTH.
- One sub-module: snn_weight_regfile, holding NUM_PRE x W_WIDTH registers with the write port and a parallel read of all weights. The neuron holds the FSM, leak, accumulate and compare logic.

Test Plan:
- Reset: assert rst_n=0 mid-integration (v_mem=150) -> immediately v_mem=0, post_spike=0, spike_count=0, weights read 0.
- Basic fire: weights all 64, thresh=200, LEAK_SHIFT=3.
  - pre_spike=5'b00111 for 1 cycle -> v_mem=192.
  - Idle cycle -> v_mem=168.
  - pre_spike=5'b00001 -> v_raw=211 -> post_spike=1 for one cycle, v_mem=0, spike_count=1.
- Refractory: REFRACT_CYCLES=4, weights 255, thresh=10, pre_spike=5'b11111 held.
  - post_spike pulses on cycles 0, 5, 10 (4 blanked cycles between).
  - refractory is high for exactly 4 cycles after each pulse.
- Saturation: LEAK_SHIFT=0, weights[0]=255, thresh=1023, pre_spike[0] held.
  - v_mem = 255, 510, 765, 1020, then clamps to 1023 -> fire on the 5th cycle.
- Write collision and bad address:
  - Write w_addr=0, w_data=100 in the same cycle as pre_spike[0] with old weight 20 -> v_mem rises by 20 (minus leak). The next spike adds 100.
  - A write to w_addr=6 changes no weight.
- Counter wrap: 256 forced fires with thresh=0 -> spike_count returns to 0.
